rf_wb_queue: RTL
================

// Module: rf_wb_queue
// PURPOSE
//   Writer side of the register file write port: buffers writeback requests from execute/memory,
//   drains them in order onto the rf write port (rd_wen/rd_waddr/rd_wdata), one per cycle.
//   Tracks pending destination registers (scoreboard) so decode can stall on RAW hazards.
//   Sits between the writeback stage and rf; rf is instantiated with BYPASS_EN=0.
// PARAMETERS
//   DEPTH  4   queue entries; power of 2, >= 2
//   XLEN   32  data width
// PORTS
//   i_clk        in   1                 clock, rising edge
//   i_rst_n      in   1                 reset, asynchronous, active-low
//   i_wb_valid   in   1                 writeback request valid
//   o_wb_ready   out  1                 queue can accept request
//   i_wb_addr    in   5                 destination register
//   i_wb_data    in   XLEN              destination data
//   i_hold       in   1                 1 = rf write port unavailable; no drain this cycle
//   o_rd_wen     out  1                 rf write enable
//   o_rd_waddr   out  5                 rf write address
//   o_rd_wdata   out  XLEN              rf write data
//   i_chk1_addr  in   5                 scoreboard lookup 1 (rs1)
//   o_chk1_busy  out  1                 i_chk1_addr has a queued write
//   i_chk2_addr  in   5                 scoreboard lookup 2 (rs2)
//   o_chk2_busy  out  1                 i_chk2_addr has a queued write
//   o_chk1_hit   out  1                 forward hit, port 1 (see CONFIGURATION)
//   o_chk1_data  out  XLEN              forward data, port 1
//   o_chk2_hit   out  1                 forward hit, port 2
//   o_chk2_data  out  XLEN              forward data, port 2
//   o_count      out  $clog2(DEPTH+1)   valid entries
//   o_empty      out  1                 o_count == 0
// BEHAVIOUR
//   - Circular FIFO, rd/wr pointers one bit wider than index; full = MSBs differ, rest equal.
//   - Reset (async, i_rst_n=0): pointers/count to 0, all entries invalid; immediately
//     o_rd_wen=0, o_count=0, o_empty=1, o_wb_ready=1, all busy/hit=0, data=0. Mid-operation
//     reset discards queued entries; no partial write reaches rf.
//   - Enqueue handshake: accepted on rising edge when i_wb_valid && o_wb_ready.
//     o_wb_ready = !full; no pass-through when full, even if a drain occurs the same cycle.
//   - i_wb_addr==0: handshake completes, entry NOT stored; count unchanged; never drives rf.
//   - Drain: o_rd_wen = !empty && !i_hold; o_rd_waddr/o_rd_wdata = head entry (combinational
//     from registered head); head pops at the edge where o_rd_wen=1. o_rd_waddr/wdata = 0 when empty.
//   - Latency: request accepted at edge N into empty queue -> o_rd_wen=1 during cycle after
//     edge N -> rf commits at edge N+1.
//   - Simultaneous enqueue+drain: count unchanged, both pointers advance.
//   - Ordering strictly FIFO; multiple entries to same register all drain, oldest first.
//   - Pointers wrap modulo DEPTH; count saturates at DEPTH only via full gating.
//   - Scoreboard: busy = any valid entry (head included, until it pops) with matching addr;
//     lookup of x0 always busy=0. Combinational on current queue state, not on incoming request.
// CONFIGURATION
//   Macro WB_QUEUE_FWD_EN:
//   - Defined: o_chkN_hit = o_chkN_busy; o_chkN_data = data of YOUNGEST matching valid
//     entry (0 when no hit). Decode may forward instead of stalling.
//   - Undefined: o_chkN_hit=0, o_chkN_data=0 constantly; no youngest-match logic built.
//     Ports exist in both builds.
// TESTING
//   1 Reset: hold i_rst_n=0 two cycles -> o_empty=1, o_count=0, o_rd_wen=0, o_wb_ready=1.
//   2 i_hold=0, push x5=0x12345678 -> next cycle o_rd_wen=1, waddr=5, wdata=0x12345678
//     for exactly one cycle; o_count back to 0.
//   3 i_hold=1, push x1..x4 = 0xAAAA0001..0xAAAA0004 (DEPTH=4) -> o_wb_ready=0, o_count=4,
//     chk1 x3 busy=1, chk2 x7 busy=0; drop hold -> 4 back-to-back writes x1..x4 in order.
//   4 Push x0=0xDEADBEEF -> accepted, o_count stays 0, o_rd_wen never asserts, chk x0 busy=0.
//   5 i_hold=1, push x9=0x11111111 then x9=0x22222222 -> busy=1; with WB_QUEUE_FWD_EN
//     hit=1, data=0x22222222 (without: hit=0, data=0); drain writes 0x11111111 then 0x22222222.
//   6 i_hold=1, 3 entries queued, pulse i_rst_n=0 mid-cycle -> o_rd_wen/o_count/busy drop
//     to 0 asynchronously; after release, no stale write appears.

Source files
------------

// File: rtl/rf_wb_queue_if.sv
// Writeback request / rf write port bundle for rf_wb_queue.
// Macro WB_QUEUE_FWD_EN only affects the queue itself, not this bundle.
interface rf_wb_queue_if #(
  parameter int XLEN = 32
);
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            hold;
  logic            rd_wen;
  logic [4:0]      rd_waddr;
  logic [XLEN-1:0] rd_wdata;

  modport master (
    output wb_valid, wb_addr, wb_data, hold,
    input  wb_ready, rd_wen, rd_waddr, rd_wdata
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, hold,
    output wb_ready, rd_wen, rd_waddr, rd_wdata
  );
endinterface

// File: rtl/rf_wb_queue.sv
// In-order writeback queue with RAW scoreboard feeding the rf write port.
// Define WB_QUEUE_FWD_EN to build youngest-match forwarding on the chk ports.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wb_valid,
  output logic                       o_wb_ready,
  input  logic [4:0]                 i_wb_addr,
  input  logic [XLEN-1:0]            i_wb_data,
  input  logic                       i_hold,
  output logic                       o_rd_wen,
  output logic [4:0]                 o_rd_waddr,
  output logic [XLEN-1:0]            o_rd_wdata,
  input  logic [4:0]                 i_chk1_addr,
  output logic                       o_chk1_busy,
  input  logic [4:0]                 i_chk2_addr,
  output logic                       o_chk2_busy,
  output logic                       o_chk1_hit,
  output logic [XLEN-1:0]            o_chk1_data,
  output logic                       o_chk2_hit,
  output logic [XLEN-1:0]            o_chk2_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef logic [AW:0] ptr_t;

  ptr_t            wr_ptr_q, wr_ptr_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]      addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic [AW-1:0] wr_idx, rd_idx;
  logic          full, empty;
  logic          push, pop;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_idx == rd_idx);

  // x0 requests complete the handshake but are never stored
  assign push = i_wb_valid && !full && (i_wb_addr != 5'd0);
  assign pop  = !empty && !i_hold;

  assign o_wb_ready = !full;
  assign o_empty    = empty;
  assign o_count    = CW'(wr_ptr_q - rd_ptr_q);
  assign o_rd_wen   = pop;
  assign o_rd_waddr = empty ? 5'd0 : addr_q[rd_idx];
  assign o_rd_wdata = empty ? '0 : data_q[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_t'(push);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    vld_d    = vld_q;
    if (pop)  vld_d[rd_idx] = 1'b0;
    if (push) vld_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      if (push) begin
        addr_q[wr_idx] <= i_wb_addr;
        data_q[wr_idx] <= i_wb_data;
      end
    end
  end

  function automatic logic busy_of(input logic [4:0] a);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && addr_q[i] == a) b = 1'b1;
    return b && (a != 5'd0);
  endfunction

  assign o_chk1_busy = busy_of(i_chk1_addr);
  assign o_chk2_busy = busy_of(i_chk2_addr);

`ifdef WB_QUEUE_FWD_EN
  // walk oldest to youngest so the last match wins
  function automatic logic [XLEN-1:0] youngest(input logic [4:0] a);
    logic [AW-1:0] idx;
    logic [XLEN-1:0] d;
    d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_idx + AW'(k);
      if (vld_q[idx] && addr_q[idx] == a) d = data_q[idx];
    end
    return (a != 5'd0) ? d : '0;
  endfunction

  assign o_chk1_hit  = o_chk1_busy;
  assign o_chk2_hit  = o_chk2_busy;
  assign o_chk1_data = youngest(i_chk1_addr);
  assign o_chk2_data = youngest(i_chk2_addr);
`else
  assign o_chk1_hit  = 1'b0;
  assign o_chk2_hit  = 1'b0;
  assign o_chk1_data = '0;
  assign o_chk2_data = '0;
`endif

endmodule
